buf_manager: RTL and testbench

//   Buffer-ID allocator on a Wishbone slave port. Tracks NBUFS buffers (IDs 0..NBUFS-1).
//   A read of ALLOC at address 0 hands out a free ID and marks it used.
//   A write of an ID to address 0 returns that ID to the pool.

---
 rtl/buf_manager_if.sv | 24 ++
 rtl/buf_manager.sv | 98 +++++++++
 tb/tb_buf_manager.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buf_manager_if.sv
// Wishbone slave bundle for the buffer-ID allocator.
// The master drives the request fields; the slave returns ack and read data.
interface buf_manager_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wbs_address;
  logic [DATA_WIDTH-1:0] wbs_writedata;
  logic [DATA_WIDTH-1:0] wbs_readdata;
  logic                  wbs_strobe;
  logic                  wbs_cycle;
  logic                  wbs_write;
  logic                  wbs_ack;

  modport master (
    output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
    input  wbs_readdata, wbs_ack
  );

  modport slave (
    input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
    output wbs_readdata, wbs_ack
  );
endinterface

// File: rtl/buf_manager.sv
// Buffer-ID allocator: hands out the lowest free ID on an ALLOC read and returns
// IDs to the pool on a write, with a free counter and sticky error flags.
module buf_manager #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NBUFS      = 13
) (
  input  logic           clk,
  input  logic           reset,
  buf_manager_if.slave   wbs
);
  localparam int CW = $clog2(NBUFS + 1);
  localparam int IW = (NBUFS > 1) ? $clog2(NBUFS) : 1;

  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NBUFS-1:0]      r_used;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_status;

  logic                  w_req;
  logic                  w_found;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_fid;
  logic                  w_fvalid;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [NBUFS-1:0]      w_used_nx;
  logic [CW-1:0]         w_count_nx;
  logic [1:0]            w_status_nx;

  // The ack cycle masks the request so a held strobe is not executed twice.
  assign w_req = wbs.wbs_strobe & wbs.wbs_cycle & ~r_ack;

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NBUFS - 1; i >= 0; i--) begin
      if (!r_used[i]) begin
        w_found = 1'b1;
        w_idx   = IW'(i);
      end
    end
  end

  assign w_fid    = wbs.wbs_writedata[IW-1:0];
  assign w_fvalid = (wbs.wbs_writedata < DATA_WIDTH'(NBUFS)) && r_used[w_fid];

  always_comb begin
    w_used_nx   = r_used;
    w_count_nx  = r_count;
    w_status_nx = r_status;
    w_rdata     = '0;
    if (w_req) begin
      if (wbs.wbs_address == ADDR_WIDTH'(0)) begin
        if (!wbs.wbs_write) begin
          if (w_found) begin
            w_rdata          = DATA_WIDTH'(w_idx);
            w_used_nx[w_idx] = 1'b1;
            w_count_nx       = r_count - CW'(1);
          end else begin
            w_rdata        = '1;
            w_status_nx[0] = 1'b1;
          end
        end else if (w_fvalid) begin
          w_used_nx[w_fid] = 1'b0;
          w_count_nx       = r_count + CW'(1);
        end else begin
          w_status_nx[1] = 1'b1;
        end
      end else if (wbs.wbs_address == ADDR_WIDTH'(1)) begin
        if (!wbs.wbs_write) w_rdata = DATA_WIDTH'(r_count);
      end else if (wbs.wbs_address == ADDR_WIDTH'(2)) begin
        if (!wbs.wbs_write) w_rdata = DATA_WIDTH'(r_status);
        else                w_status_nx = r_status & ~wbs.wbs_writedata[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_used   <= '0;
      r_count  <= CW'(NBUFS);
      r_status <= '0;
    end else begin
      r_ack    <= w_req;
      r_rdata  <= w_rdata;
      r_used   <= w_used_nx;
      r_count  <= w_count_nx;
      r_status <= w_status_nx;
    end
  end

  assign wbs.wbs_ack      = r_ack;
  assign wbs.wbs_readdata = r_rdata;
endmodule

// File: tb/tb_buf_manager.sv
// Directed bench for buf_manager: allocation order, underflow, frees, bad frees,
// held strobe and reset during a transfer.
module tb_buf_manager;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  buf_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  buf_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NBUFS(NB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .wbs   (bus.slave)
  );

  task automatic bus_idle();
    bus.wbs_strobe    = 1'b0;
    bus.wbs_cycle     = 1'b0;
    bus.wbs_write     = 1'b0;
    bus.wbs_address   = '0;
    bus.wbs_writedata = '0;
  endtask

  // lat = edges from request to ack; 99 if no ack arrived in the budget.
  task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output int lat);
    @(posedge clk);
    @(negedge clk);
    bus.wbs_strobe    = 1'b1;
    bus.wbs_cycle     = 1'b1;
    bus.wbs_write     = we;
    bus.wbs_address   = a;
    bus.wbs_writedata = wd;
    lat = 99;
    rd  = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack) begin
        lat = k;
        rd  = bus.wbs_readdata;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    xfer(1'b0, a, '0, d, lat);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] wd, output int lat);
    logic [DW-1:0] dummy;
    xfer(1'b1, a, wd, dummy, lat);
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    int lat;
    rst_n = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.wbs_ack !== 1'b0 || bus.wbs_readdata !== '0) begin
      errors++; $display("FAIL reset_outputs: ack=%b rdata=%h want ack=0 rdata=0", bus.wbs_ack, bus.wbs_readdata);
    end
    @(negedge clk) rst_n = 1'b1;
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd13 || lat !== 1) begin
      errors++; $display("FAIL reset_free_count: got %0d lat %0d want 13 lat 1", d, lat);
    end
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'd0 || lat !== 1) begin
      errors++; $display("FAIL reset_status: got %h lat %0d want 0 lat 1", d, lat);
    end
  endtask

  task automatic test_alloc_all();
    logic [DW-1:0] d;
    int lat;
    for (int i = 0; i < NB; i++) begin
      rd(16'd0, d, lat);
      checks++;
      if (d !== DW'(i) || lat !== 1) begin
        errors++; $display("FAIL alloc_%0d: got %h lat %0d want %h lat 1", i, d, lat, i);
      end
    end
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL alloc_all_count: got %0d want 0", d);
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] d;
    int lat;
    rd(16'd0, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || lat !== 1) begin
      errors++; $display("FAIL underflow_data: got %h lat %0d want ffffffff lat 1", d, lat);
    end
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL underflow_count: got %0d want 0", d);
    end
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL underflow_flag: got %h want 1", d);
    end
    wr(16'd2, 32'h1, lat);
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL underflow_clear: got %h want 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int lat;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        wr(16'd0, DW'(i), lat);
        checks++;
        if (lat !== 1) begin
          errors++; $display("FAIL b2b_free_lat p%0d id%0d: got %0d want 1", p, i, lat);
        end
      end
      rd(16'd1, d, lat);
      checks++;
      if (d !== 32'd13) begin
        errors++; $display("FAIL b2b_count p%0d: got %0d want 13", p, d);
      end
      for (int i = 0; i < NB; i++) begin
        rd(16'd0, d, lat);
        checks++;
        if (d !== DW'(i)) begin
          errors++; $display("FAIL b2b_alloc p%0d id%0d: got %h want %h", p, i, d, i);
        end
      end
      rd(16'd2, d, lat);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL b2b_status p%0d: got %h want 0", p, d);
      end
    end
  endtask

  task automatic test_lowest();
    logic [DW-1:0] d;
    int lat;
    wr(16'd0, 32'd5, lat);
    wr(16'd0, 32'd2, lat);
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd2) begin
      errors++; $display("FAIL lowest_count: got %0d want 2", d);
    end
    rd(16'd0, d, lat);
    checks++;
    if (d !== 32'd2) begin
      errors++; $display("FAIL lowest_first: got %0d want 2", d);
    end
    rd(16'd0, d, lat);
    checks++;
    if (d !== 32'd5) begin
      errors++; $display("FAIL lowest_second: got %0d want 5", d);
    end
  endtask

  task automatic test_bad_free();
    logic [DW-1:0] d;
    int lat;
    wr(16'd0, 32'd7, lat);
    wr(16'd0, 32'd13, lat);
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL badfree_range_flag: got %h want 2", d);
    end
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL badfree_range_count: got %0d want 1", d);
    end
    wr(16'd2, 32'h2, lat);
    wr(16'd0, 32'd7, lat);
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL badfree_double_flag: got %h want 2", d);
    end
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL badfree_double_count: got %0d want 1", d);
    end
    wr(16'd2, 32'h3, lat);
    rd(16'd3, d, lat);
    checks++;
    if (d !== 32'd0 || lat !== 1) begin
      errors++; $display("FAIL unmapped_read: got %h lat %0d want 0 lat 1", d, lat);
    end
    // Address 0x100 aliases 0 under a partial decode; freeing ID 0 there must not happen.
    wr(16'h0100, 32'd0, lat);
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd1 || lat !== 1) begin
      errors++; $display("FAIL unmapped_write: got %0d lat %0d want 1 lat 1", d, lat);
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] d;
    int lat;
    int acks;
    logic [DW-1:0] cap;
    acks = 0;
    cap  = '1;
    @(posedge clk);
    @(negedge clk);
    bus.wbs_strobe  = 1'b1;
    bus.wbs_cycle   = 1'b1;
    bus.wbs_write   = 1'b0;
    bus.wbs_address = 16'd0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack) begin
        acks++;
        cap = bus.wbs_readdata;
      end
    end
    bus_idle();
    checks++;
    if (acks !== 1 || cap !== 32'd7) begin
      errors++; $display("FAIL hold_ack: acks %0d data %h want 1 ack data 7", acks, cap);
    end
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL hold_count: got %0d want 0", d);
    end
    rd(16'd2, d, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL hold_status: got %h want 0", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int lat;
    @(posedge clk);
    @(negedge clk);
    bus.wbs_strobe  = 1'b1;
    bus.wbs_cycle   = 1'b1;
    bus.wbs_write   = 1'b0;
    bus.wbs_address = 16'd1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.wbs_ack !== 1'b1) begin
      errors++; $display("FAIL midreset_pre_ack: got %b want 1", bus.wbs_ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wbs_ack !== 1'b0 || bus.wbs_readdata !== '0) begin
      errors++; $display("FAIL midreset_ack_drop: ack %b rdata %h want 0 0", bus.wbs_ack, bus.wbs_readdata);
    end
    bus_idle();
    @(negedge clk) rst_n = 1'b1;
    rd(16'd1, d, lat);
    checks++;
    if (d !== 32'd13) begin
      errors++; $display("FAIL midreset_count: got %0d want 13", d);
    end
    rd(16'd0, d, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL midreset_alloc: got %0d want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_all();
    test_underflow();
    test_back_to_back();
    test_lowest();
    test_bad_free();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
